// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared definitions for the multi-cycle MIPS-subset core.
//   state_t  - FSM state encoding (also exported on the core's state port)
//   OP_*     - primary opcode field values
//   FN_*     - R-type funct field values
//   alu_op_t - ALU operation select
//   funct_legal / funct_to_alu - R-type funct decode helpers
package mc_cpu_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      EXEC_R    = 4'd2,
      WB_R      = 4'd3,
      EXEC_I    = 4'd4,
      WB_I      = 4'd5,
      MEM_ADDR  = 4'd6,
      MEM_READ  = 4'd7,
      WB_MEM    = 4'd8,
      MEM_WRITE = 4'd9,
      BRANCH    = 4'd10,
      JUMP      = 4'd11,
      HALT      = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_NOR = 3'd4,
      ALU_SLT = 3'd5
   } alu_op_t;

   // True for the R-type funct codes the core implements.
   function automatic logic funct_legal(input logic [5:0] funct);
      logic ok;
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: ok = 1'b1;
         default:                                       ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Maps an R-type funct code onto an ALU operation.
   function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
      alu_op_t op;
      case (funct)
         FN_ADD:  op = ALU_ADD;
         FN_SUB:  op = ALU_SUB;
         FN_AND:  op = ALU_AND;
         FN_OR:   op = ALU_OR;
         FN_NOR:  op = ALU_NOR;
         FN_SLT:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mc_cpu_regfile.sv
// mc_cpu_regfile: NREG x DATA_W register file, register 0 hard-wired to zero.
//   clk, rst           - clock, synchronous active-high reset (clears all registers)
//   ra_addr / ra_data  - read port A (combinational)
//   rb_addr / rb_data  - read port B (combinational)
//   dbg_addr / dbg_data- debug read port (combinational)
//   wr_en, wr_addr, wr_data - write port, takes effect on the rising edge
// Address bits above log2(NREG) are ignored.
module mc_cpu_regfile #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [4:0]        rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int RW = $clog2(NREG);

   logic [DATA_W-1:0] regs_r [NREG];

   // Register storage; writes aimed at register 0 are dropped so it always reads zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wr_en && (wr_addr[RW-1:0] != '0)) begin
         regs_r[wr_addr[RW-1:0]] <= wr_data;
      end
   end

   assign ra_data  = regs_r[ra_addr[RW-1:0]];
   assign rb_data  = regs_r[rb_addr[RW-1:0]];
   assign dbg_data = regs_r[dbg_addr[RW-1:0]];

endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle MIPS-subset CPU with a request/ready memory port.
//   clk, rst         - system clock, synchronous active-high reset
//   run              - advance enable; all state (incl. cycle_count) holds when 0
//   mem_req/mem_we   - memory request and write strobe, held until mem_ready
//   mem_addr         - word address; mem_wdata store data
//   mem_rdata        - read data, valid together with mem_ready
//   dbg_index/dbg_data - combinational register read for board debug
//   pc, state        - current byte PC and FSM state
//   cycle_count      - run=1 cycles since reset, frozen once halted
//   halted, illegal  - core stopped; sticky flag for undefined opcode/funct
module mc_cpu_core
   import mc_cpu_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int          ADDR_W   = 9,
   parameter int          NREG     = 32,
   parameter int unsigned RESET_PC = 32'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic [4:0]        dbg_index,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] pc,
   output logic [3:0]        state,
   output logic [31:0]       cycle_count,
   output logic              halted,
   output logic              illegal
);

   state_t            state_r;
   logic [DATA_W-1:0] pc_r;
   logic [31:0]       ir_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [DATA_W-1:0] aluout_r;
   logic [DATA_W-1:0] mdr_r;
   logic [31:0]       cycle_count_r;
   logic              halted_r;
   logic              illegal_r;

   // Instruction fields
   logic [5:0]        opcode_s;
   logic [4:0]        rs_s;
   logic [4:0]        rt_s;
   logic [4:0]        rd_s;
   logic [5:0]        funct_s;
   logic [DATA_W-1:0] imm_ext_s;
   logic [DATA_W-1:0] br_off_s;
   logic [DATA_W-1:0] jump_target_s;

   assign opcode_s      = ir_r[31:26];
   assign rs_s          = ir_r[25:21];
   assign rt_s          = ir_r[20:16];
   assign rd_s          = ir_r[15:11];
   assign funct_s       = ir_r[5:0];
   assign imm_ext_s     = {{(DATA_W-16){ir_r[15]}}, ir_r[15:0]};
   assign br_off_s      = {imm_ext_s[DATA_W-3:0], 2'b00};
   assign jump_target_s = {pc_r[DATA_W-1:28], ir_r[25:0], 2'b00};

   // Register file hookup
   logic [DATA_W-1:0] rf_a_s;
   logic [DATA_W-1:0] rf_b_s;
   logic              rf_we_s;
   logic [4:0]        rf_waddr_s;
   logic [DATA_W-1:0] rf_wdata_s;

   mc_cpu_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .ra_addr  (rs_s),
      .ra_data  (rf_a_s),
      .rb_addr  (rt_s),
      .rb_data  (rf_b_s),
      .dbg_addr (dbg_index),
      .dbg_data (dbg_data),
      .wr_en    (rf_we_s),
      .wr_addr  (rf_waddr_s),
      .wr_data  (rf_wdata_s)
   );

   // Write-back port: the WB states commit on the same run-qualified edge that leaves them.
   always_comb begin
      rf_we_s    = 1'b0;
      rf_waddr_s = rt_s;
      rf_wdata_s = aluout_r;
      case (state_r)
         WB_R: begin
            rf_we_s    = run;
            rf_waddr_s = rd_s;
         end
         WB_I: begin
            rf_we_s    = run;
         end
         WB_MEM: begin
            rf_we_s    = run;
            rf_wdata_s = mdr_r;
         end
         default: begin
            rf_we_s    = 1'b0;
         end
      endcase
   end

   // ALU: R-type uses B and funct; EXEC_I and MEM_ADDR add the sign-extended immediate.
   alu_op_t           alu_op_s;
   logic [DATA_W-1:0] alu_b_s;
   logic [DATA_W-1:0] alu_res_s;

   // ALU operand/operation select
   always_comb begin
      alu_op_s = ALU_ADD;
      alu_b_s  = imm_ext_s;
      if (state_r == EXEC_R) begin
         alu_op_s = funct_to_alu(funct_s);
         alu_b_s  = b_r;
      end else begin
         alu_op_s = ALU_ADD;
         alu_b_s  = imm_ext_s;
      end
   end

   // ALU datapath
   always_comb begin
      alu_res_s = '0;
      case (alu_op_s)
         ALU_ADD: alu_res_s = a_r + alu_b_s;
         ALU_SUB: alu_res_s = a_r - alu_b_s;
         ALU_AND: alu_res_s = a_r & alu_b_s;
         ALU_OR:  alu_res_s = a_r | alu_b_s;
         ALU_NOR: alu_res_s = ~(a_r | alu_b_s);
         ALU_SLT: alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(a_r) < $signed(alu_b_s))};
         default: alu_res_s = a_r + alu_b_s;
      endcase
   end

   // Memory port decode from the state register; reset forces the request low.
   logic              mem_req_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_addr_s;

   // Memory request/address select
   always_comb begin
      mem_req_s  = 1'b0;
      mem_we_s   = 1'b0;
      mem_addr_s = pc_r[ADDR_W+1:2];
      case (state_r)
         FETCH: begin
            mem_req_s  = 1'b1;
            mem_addr_s = pc_r[ADDR_W+1:2];
         end
         MEM_READ: begin
            mem_req_s  = 1'b1;
            mem_addr_s = aluout_r[ADDR_W+1:2];
         end
         MEM_WRITE: begin
            mem_req_s  = 1'b1;
            mem_we_s   = 1'b1;
            mem_addr_s = aluout_r[ADDR_W+1:2];
         end
         default: begin
            mem_req_s  = 1'b0;
         end
      endcase
   end

   assign mem_req   = mem_req_s & ~rst;
   assign mem_we    = mem_we_s & ~rst;
   assign mem_addr  = mem_addr_s;
   assign mem_wdata = b_r;

   // Main FSM and datapath registers; nothing moves on an edge with run=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= FETCH;
         pc_r          <= DATA_W'(RESET_PC);
         ir_r          <= 32'd0;
         a_r           <= '0;
         b_r           <= '0;
         aluout_r      <= '0;
         mdr_r         <= '0;
         cycle_count_r <= 32'd0;
         halted_r      <= 1'b0;
         illegal_r     <= 1'b0;
      end else if (run) begin
         if (!halted_r) begin
            cycle_count_r <= cycle_count_r + 32'd1;
         end
         case (state_r)
            FETCH: begin
               if (mem_ready) begin
                  ir_r    <= mem_rdata[31:0];
                  pc_r    <= pc_r + DATA_W'(32'd4);
                  state_r <= DECODE;
               end
            end
            DECODE: begin
               a_r      <= rf_a_s;
               b_r      <= rf_b_s;
               aluout_r <= pc_r + br_off_s;
               case (opcode_s)
                  OP_RTYPE:      state_r <= EXEC_R;
                  OP_LW, OP_SW:  state_r <= MEM_ADDR;
                  OP_BEQ, OP_BNE: state_r <= BRANCH;
                  OP_J:          state_r <= JUMP;
                  OP_ADDI:       state_r <= EXEC_I;
                  OP_HALT: begin
                     state_r  <= HALT;
                     halted_r <= 1'b1;
                  end
                  default: begin
                     state_r   <= HALT;
                     halted_r  <= 1'b1;
                     illegal_r <= 1'b1;
                  end
               endcase
            end
            EXEC_R: begin
               if (funct_legal(funct_s)) begin
                  aluout_r <= alu_res_s;
                  state_r  <= WB_R;
               end else begin
                  state_r   <= HALT;
                  halted_r  <= 1'b1;
                  illegal_r <= 1'b1;
               end
            end
            EXEC_I: begin
               aluout_r <= alu_res_s;
               state_r  <= WB_I;
            end
            MEM_ADDR: begin
               aluout_r <= alu_res_s;
               state_r  <= (opcode_s == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
               if (mem_ready) begin
                  mdr_r   <= mem_rdata;
                  state_r <= WB_MEM;
               end
            end
            MEM_WRITE: begin
               if (mem_ready) begin
                  state_r <= FETCH;
               end
            end
            WB_R, WB_I, WB_MEM: begin
               state_r <= FETCH;
            end
            BRANCH: begin
               // beq takes on equality, bne on inequality
               if ((opcode_s == OP_BEQ) == (a_r == b_r)) begin
                  pc_r <= aluout_r;
               end
               state_r <= FETCH;
            end
            JUMP: begin
               pc_r    <= jump_target_s;
               state_r <= FETCH;
            end
            HALT: begin
               state_r <= HALT;
            end
            default: begin
               state_r  <= HALT;
               halted_r <= 1'b1;
            end
         endcase
      end
   end

   assign pc          = pc_r;
   assign state       = state_r;
   assign cycle_count = cycle_count_r;
   assign halted      = halted_r;
   assign illegal     = illegal_r;

endmodule

// File: tb/tb_mc_cpu_core.sv
// Self-checking bench for mc_cpu_core: directed scenarios plus random programs
// compared against an instruction-level interpreter with a per-instruction cycle cost.
module tb_mc_cpu_core;
   import mc_cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        mem_req;
   logic        mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [4:0]  dbg_index;
   logic [31:0] dbg_data;
   logic [31:0] pc;
   logic [3:0]  state;
   logic [31:0] cycle_count;
   logic        halted;
   logic        illegal;

   int errors = 0;
   int checks = 0;

   mc_cpu_core #(.DATA_W(32), .ADDR_W(9), .NREG(32), .RESET_PC(32'd0)) dut (
      .clk(clk), .rst(rst), .run(run),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .dbg_index(dbg_index), .dbg_data(dbg_data),
      .pc(pc), .state(state), .cycle_count(cycle_count),
      .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Memory model: ready after wait_cycles of request, held until accepted.
   logic [31:0] mem [512];
   int          wait_cycles = 0;
   int          wcnt = 0;
   logic        auto_mem = 1'b1;
   logic        man_ready = 1'b0;
   logic [31:0] man_rdata = 32'd0;

   assign mem_ready = auto_mem ? (mem_req && (wcnt >= wait_cycles)) : man_ready;
   assign mem_rdata = auto_mem ? mem[mem_addr] : man_rdata;

   initial begin
      logic       acc, req_c, we_c;
      logic [8:0] addr_c;
      logic [31:0] wd_c;
      forever begin
         @(posedge clk);
         acc    = auto_mem && mem_req && mem_ready && run && !rst;
         req_c  = mem_req;
         we_c   = mem_we;
         addr_c = mem_addr;
         wd_c   = mem_wdata;
         @(negedge clk);
         if (acc) begin
            if (we_c) mem[addr_c] = wd_c;
            wcnt = 0;
         end else if (!req_c) begin
            wcnt = 0;
         end else if (wcnt < wait_cycles) begin
            wcnt = wcnt + 1;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   // Instruction encoders
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction
   localparam logic [31:0] I_HALT = 32'hFC00_0000;

   // Reference interpreter
   logic [31:0] m_regs [32];
   logic [31:0] m_mem  [512];
   logic [31:0] m_pc;
   int          m_cycles;
   logic        m_illegal;

   task automatic model_run(input int w);
      logic [31:0] instr, a, b, imm, res, addr;
      logic [5:0]  op;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pc = 32'd0; m_cycles = 0; m_illegal = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         instr = m_mem[m_pc[10:2]];
         m_pc  = m_pc + 32'd4;
         op    = instr[31:26];
         a     = m_regs[instr[25:21]];
         b     = m_regs[instr[20:16]];
         imm   = {{16{instr[15]}}, instr[15:0]};
         if (op == 6'h00) begin
            case (instr[5:0])
               6'h20: res = a + b;
               6'h22: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h27: res = ~(a | b);
               6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: begin m_cycles += 3 + w; m_illegal = 1'b1; return; end
            endcase
            if (instr[15:11] != 5'd0) m_regs[instr[15:11]] = res;
            m_cycles += 4 + w;
         end else if (op == 6'h08) begin
            if (instr[20:16] != 5'd0) m_regs[instr[20:16]] = a + imm;
            m_cycles += 4 + w;
         end else if (op == 6'h23) begin
            addr = a + imm;
            if (instr[20:16] != 5'd0) m_regs[instr[20:16]] = m_mem[addr[10:2]];
            m_cycles += 5 + 2 * w;
         end else if (op == 6'h2B) begin
            addr = a + imm;
            m_mem[addr[10:2]] = b;
            m_cycles += 4 + 2 * w;
         end else if (op == 6'h04 || op == 6'h05) begin
            if ((op == 6'h04) ? (a == b) : (a != b)) m_pc = m_pc + (imm << 2);
            m_cycles += 3 + w;
         end else if (op == 6'h02) begin
            m_pc = {m_pc[31:28], instr[25:0], 2'b00};
            m_cycles += 3 + w;
         end else begin
            m_cycles += 2 + w;
            m_illegal = (op != 6'h3F);
            return;
         end
      end
   endtask

   // Bench sequencing helpers (no comparisons except the halt timeout)
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; run = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; run = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = I_HALT;
   endtask

   task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
      dbg_index = idx;
      #1;
      val = dbg_data;
   endtask

   task automatic run_until_halted(input int budget);
      int n;
      n = 0;
      run = 1'b1;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      run = 1'b0;
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_timeout: halted=%0b required 1 after %0d cycles", halted, n);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      @(negedge clk);
      rst = 1'b1; run = 1'b1;
      repeat (2) @(negedge clk);
      read_reg(5'd5, v);
      checks += 8;
      if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h required 0", pc); end
      if (state !== FETCH) begin errors++; $display("FAIL reset_state: got %0d required %0d", state, FETCH); end
      if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cc: got %0d required 0", cycle_count); end
      if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
      if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b required 0", illegal); end
      if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", mem_req); end
      if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", mem_we); end
      if (v !== 32'd0) begin errors++; $display("FAIL reset_reg: got %h required 0", v); end
      rst = 1'b0; run = 1'b0;
   endtask

   task automatic test_basic_program();
      logic [31:0] v1, v2, v3;
      clear_mem();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
      mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      mem[3] = I_HALT;
      wait_cycles = 0;
      apply_reset();
      run_until_halted(200);
      read_reg(5'd1, v1); read_reg(5'd2, v2); read_reg(5'd3, v3);
      checks += 6;
      if (v1 !== 32'd5) begin errors++; $display("FAIL basic_r1: got %h required 5", v1); end
      if (v2 !== 32'd7) begin errors++; $display("FAIL basic_r2: got %h required 7", v2); end
      if (v3 !== 32'd12) begin errors++; $display("FAIL basic_r3: got %h required c", v3); end
      if (illegal !== 1'b0) begin errors++; $display("FAIL basic_illegal: got %b required 0", illegal); end
      if (pc !== 32'h10) begin errors++; $display("FAIL basic_pc: got %h required 10", pc); end
      if (cycle_count !== 32'd14) begin errors++; $display("FAIL basic_cc: got %0d required 14", cycle_count); end
   endtask

   task automatic test_mem_wait();
      logic [31:0] v4;
      clear_mem();
      mem[0]  = enc_i(6'h08, 5'd0, 5'd3, 16'hFFFE);
      mem[1]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0100);
      mem[2]  = enc_i(6'h23, 5'd0, 5'd4, 16'h0100);
      mem[3]  = I_HALT;
      mem[64] = 32'h1111_2222;
      wait_cycles = 3;
      apply_reset();
      run = 1'b1;
      repeat (17) @(negedge clk);
      run = 1'b0;
      checks += 2;
      if (state !== FETCH) begin errors++; $display("FAIL wait_sw_state: got %0d required %0d", state, FETCH); end
      if (pc !== 32'h8) begin errors++; $display("FAIL wait_sw_pc: got %h required 8", pc); end
      run_until_halted(300);
      read_reg(5'd4, v4);
      checks += 4;
      if (mem[64] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wait_store: got %h required fffffffe", mem[64]); end
      if (v4 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wait_load: got %h required fffffffe", v4); end
      if (cycle_count !== 32'd33) begin errors++; $display("FAIL wait_cc: got %0d required 33", cycle_count); end
      if (pc !== 32'h10) begin errors++; $display("FAIL wait_pc: got %h required 10", pc); end
      wait_cycles = 0;
   endtask

   task automatic test_branch();
      clear_mem();
      mem[0] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
      mem[3] = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
      wait_cycles = 0;
      apply_reset();
      run = 1'b1;
      repeat (3) @(negedge clk);
      checks += 3;
      if (pc !== 32'h0C) begin errors++; $display("FAIL beq_pc: got %h required c", pc); end
      if (state !== FETCH) begin errors++; $display("FAIL beq_state: got %0d required %0d", state, FETCH); end
      if (mem_addr !== 9'd3) begin errors++; $display("FAIL beq_fetch_addr: got %0d required 3", mem_addr); end
      repeat (3) @(negedge clk);
      checks += 1;
      if (pc !== 32'h10) begin errors++; $display("FAIL bne_pc: got %h required 10", pc); end
      run_until_halted(50);
      checks += 2;
      if (cycle_count !== 32'd8) begin errors++; $display("FAIL branch_cc: got %0d required 8", cycle_count); end
      if (illegal !== 1'b0) begin errors++; $display("FAIL branch_illegal: got %b required 0", illegal); end
   endtask

   task automatic test_jump_illegal();
      clear_mem();
      mem[0]  = {6'h02, 26'h40};
      mem[64] = 32'hF800_0000;
      apply_reset();
      run = 1'b1;
      repeat (3) @(negedge clk);
      checks += 1;
      if (pc !== 32'h100) begin errors++; $display("FAIL jump_pc: got %h required 100", pc); end
      run_until_halted(50);
      checks += 2;
      if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b required 1", illegal); end
      if (cycle_count !== 32'd5) begin errors++; $display("FAIL illegal_cc: got %0d required 5", cycle_count); end
      run = 1'b1;
      repeat (10) @(negedge clk);
      run = 1'b0;
      checks += 4;
      if (pc !== 32'h104) begin errors++; $display("FAIL halt_hold_pc: got %h required 104", pc); end
      if (cycle_count !== 32'd5) begin errors++; $display("FAIL halt_hold_cc: got %0d required 5", cycle_count); end
      if (state !== HALT) begin errors++; $display("FAIL halt_hold_state: got %0d required %0d", state, HALT); end
      if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_hold_req: got %b required 0", mem_req); end
   endtask

   task automatic test_run_hold();
      logic [31:0] val, v5;
      val = $urandom;
      auto_mem = 1'b0;
      apply_reset();
      run = 1'b1; man_ready = 1'b1; man_rdata = enc_i(6'h23, 5'd0, 5'd5, 16'h0100);
      @(negedge clk);
      man_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks += 2;
      if (state !== MEM_READ) begin errors++; $display("FAIL hold_pre_state: got %0d required %0d", state, MEM_READ); end
      if (mem_addr !== 9'd64) begin errors++; $display("FAIL hold_addr: got %0d required 64", mem_addr); end
      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         man_ready = i[0];
         man_rdata = 32'hBAD0_0000 | 32'(i);
         @(negedge clk);
      end
      checks += 4;
      if (state !== MEM_READ) begin errors++; $display("FAIL hold_state: got %0d required %0d", state, MEM_READ); end
      if (pc !== 32'h4) begin errors++; $display("FAIL hold_pc: got %h required 4", pc); end
      if (cycle_count !== 32'd4) begin errors++; $display("FAIL hold_cc: got %0d required 4", cycle_count); end
      if (mem_req !== 1'b1) begin errors++; $display("FAIL hold_req: got %b required 1", mem_req); end
      run = 1'b1; man_ready = 1'b0;
      @(negedge clk);
      man_ready = 1'b1; man_rdata = val;
      @(negedge clk);
      man_ready = 1'b0;
      @(negedge clk);
      man_ready = 1'b1; man_rdata = I_HALT;
      @(negedge clk);
      man_ready = 1'b0;
      @(negedge clk);
      run = 1'b0;
      read_reg(5'd5, v5);
      checks += 4;
      if (v5 !== val) begin errors++; $display("FAIL hold_load: got %h required %h", v5, val); end
      if (halted !== 1'b1) begin errors++; $display("FAIL hold_halted: got %b required 1", halted); end
      if (cycle_count !== 32'd9) begin errors++; $display("FAIL hold_total_cc: got %0d required 9", cycle_count); end
      if (pc !== 32'h8) begin errors++; $display("FAIL hold_final_pc: got %h required 8", pc); end
      auto_mem = 1'b1;
   endtask

   task automatic test_rst_wait();
      logic [31:0] v0, v1;
      clear_mem();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
      wait_cycles = 3;
      apply_reset();
      run = 1'b1;
      repeat (15) @(negedge clk);
      read_reg(5'd0, v0); read_reg(5'd1, v1);
      checks += 5;
      if (state !== FETCH || mem_req !== 1'b1) begin errors++; $display("FAIL pre_rst_state: got %0d/%b required %0d/1", state, mem_req, FETCH); end
      if (pc !== 32'h8) begin errors++; $display("FAIL pre_rst_pc: got %h required 8", pc); end
      if (cycle_count !== 32'd15) begin errors++; $display("FAIL pre_rst_cc: got %0d required 15", cycle_count); end
      if (v0 !== 32'd0) begin errors++; $display("FAIL r0_write: got %h required 0", v0); end
      if (v1 !== 32'd5) begin errors++; $display("FAIL pre_rst_r1: got %h required 5", v1); end
      rst = 1'b1;
      @(negedge clk);
      read_reg(5'd1, v1);
      checks += 4;
      if (pc !== 32'd0) begin errors++; $display("FAIL rst_wait_pc: got %h required 0", pc); end
      if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_wait_cc: got %0d required 0", cycle_count); end
      if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_req: got %b required 0", mem_req); end
      if (v1 !== 32'd0) begin errors++; $display("FAIL rst_wait_r1: got %h required 0", v1); end
      rst = 1'b0; run = 1'b0;
      wait_cycles = 0;
   endtask

   task automatic test_random_programs();
      logic [5:0]  fl [6];
      logic [31:0] v;
      int          kind, w;
      fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      for (int it = 0; it < 6; it++) begin
         clear_mem();
         for (int k = 64; k < 72; k++) mem[k] = $urandom;
         for (int i = 0; i < 16; i++) begin
            kind = $urandom_range(0, 4);
            case (kind)
               0: mem[i] = enc_i(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
               1: mem[i] = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                 5'($urandom_range(0, 7)), fl[$urandom_range(0, 5)]);
               2: mem[i] = enc_i(6'h2B, 5'd0, 5'($urandom_range(0, 7)), 16'(16'h0100 + 4 * $urandom_range(0, 7)));
               3: mem[i] = enc_i(6'h23, 5'd0, 5'($urandom_range(0, 7)), 16'(16'h0100 + 4 * $urandom_range(0, 7)));
               default: mem[i] = enc_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05,
                                       5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
                                       16'($urandom_range(0, 3)));
            endcase
         end
         for (int k = 0; k < 512; k++) m_mem[k] = mem[k];
         w = $urandom_range(0, 2);
         wait_cycles = w;
         model_run(w);
         apply_reset();
         run_until_halted(2000);
         for (int r = 1; r < 8; r++) begin
            read_reg(5'(r), v);
            checks++;
            if (v !== m_regs[r]) begin errors++; $display("FAIL rand%0d_reg%0d: got %h required %h", it, r, v, m_regs[r]); end
         end
         for (int k = 64; k < 72; k++) begin
            checks++;
            if (mem[k] !== m_mem[k]) begin errors++; $display("FAIL rand%0d_mem%0d: got %h required %h", it, k, mem[k], m_mem[k]); end
         end
         checks += 3;
         if (pc !== m_pc) begin errors++; $display("FAIL rand%0d_pc: got %h required %h", it, pc, m_pc); end
         if (cycle_count !== 32'(m_cycles)) begin errors++; $display("FAIL rand%0d_cc: got %0d required %0d", it, cycle_count, m_cycles); end
         if (illegal !== m_illegal) begin errors++; $display("FAIL rand%0d_illegal: got %b required %b", it, illegal, m_illegal); end
      end
      wait_cycles = 0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; dbg_index = 5'd0;
      clear_mem();
      test_reset();
      test_basic_program();
      test_mem_wait();
      test_branch();
      test_jump_illegal();
      test_run_hold();
      test_rst_wait();
      test_random_programs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
Parametrised multi-cycle MIPS-subset core: the next generation of the board-level multi-cycle CPU. Replaces the internal clock-mux/debounce arrangement with a single system clock plus a `run` enable. Adds a ready/req memory handshake with wait states, I-type ALU and `bne` support, a halt state and a debug register read port. Board glue (debounce, 7-segment display, LED mapping) instantiates this core and drives `run` from a step pulse or a 1 s tick.

Parameters:
DATA_W, 32, datapath and register width (>=32; instruction field decode assumes 32-bit encoding)
ADDR_W, 9, word-address width of the unified instruction/data memory
NREG, 32, register count (power of two, <=32); register 0 reads as zero
RESET_PC, 0, byte address loaded into pc on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
run  in  1  advance enable; when 0 the core holds all state, including the cycle counter
mem_req  out  1  memory access request, held until accepted
mem_we  out  1  write strobe, valid with mem_req
mem_addr  out  ADDR_W  word address (byte address [ADDR_W+1:2])
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  read data, valid in the cycle mem_ready=1
mem_ready  in  1  access complete this cycle
dbg_index  in  5  debug register select (bits above log2(NREG) ignored)
dbg_data  out  DATA_W  combinational read of register dbg_index
pc  out  DATA_W  current byte PC
state  out  4  current FSM state encoding
cycle_count  out  32  cycles elapsed with run=1 since reset, frozen when halted
halted  out  1  core stopped (HALT opcode or illegal instruction)
illegal  out  1  sticky: halted because of an undefined opcode/funct

Behaviour:
- Reset (rst=1 on an edge, regardless of run): pc=RESET_PC; state=FETCH; all registers 0; ir=0; cycle_count=0; halted=0; illegal=0; mem_req=0; mem_we=0.
- State transitions and register updates occur only on edges with run=1.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc word. Stays in FETCH while mem_ready=0. On mem_ready: ir<=mem_rdata, pc<=pc+4, go to DECODE.
- DECODE: A<=R[rs], B<=R[rt], aluout<=pc+(sext(imm)<<2). Dispatch by opcode:
  - 0x00 to EXEC_R
  - 0x23/0x2B to MEM_ADDR
  - 0x04/0x05 to BRANCH
  - 0x02 to JUMP
  - 0x08 to EXEC_I
  - 0x3F to HALT
  - any other opcode: HALT with illegal=1
- EXEC_R: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed). Other funct goes to HALT with illegal=1. Otherwise to WB_R, where R[rd]<=aluout, then FETCH.
- EXEC_I: aluout<=A+sext(imm), then WB_I, where R[rt]<=aluout, then FETCH.
- MEM_ADDR: aluout<=A+sext(imm). lw goes to MEM_READ; sw goes to MEM_WRITE.
- MEM_READ/MEM_WRITE: mem_req=1 with mem_addr=aluout word, and mem_we=1 with wdata=B for a store. Wait while mem_ready=0.
  - Load: on ready, mdr<=rdata, go to WB_MEM (R[rt]<=mdr), then FETCH.
  - Store: on ready, go to FETCH.
- BRANCH: beq takes when A==B; bne takes when A!=B. If taken, pc<=aluout. Then FETCH.
- JUMP: pc<={pc[31:28],ir[25:0],2'b00}, then FETCH.
- HALT: absorbing; halted=1; cycle_count frozen; only rst exits.
- Writes to register 0 are discarded.
- Arithmetic is modulo 2^DATA_W and no overflow traps; sext is to DATA_W bits.
- Address bits above ADDR_W+1 are ignored, so addresses wrap within memory.
- cycle_count increments each run=1 edge when not halted, including wait-state cycles, and wraps at 2^32.
- Latency without wait states:
  - R / addi / lw: 4 / 4 / 5 cycles
  - sw / branch / jump: 4 / 3 / 3 cycles
  - HALT reached in 2 cycles
  - each extra cycle of mem_ready=0 adds one cycle
- run dropped during a memory wait: mem_req stays asserted and state is held. A mem_ready arriving while run=0 is ignored; the memory must keep data/ready until accepted.
- rst during a memory wait: mem_req deasserts the next cycle; no register or pc update from the aborted access.
- dbg_data reflects register writes from the edge after the write.

Decomposition:
- Package mc_cpu_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_READ, WB_MEM, MEM_WRITE, BRANCH, JUMP, HALT)
  - opcode and funct constants
  - ALU op enum
- Sub-module mc_cpu_regfile (NREG x DATA_W): two read ports, one debug read port, one write port, with register 0 forced to zero.
- ALU and FSM stay inline in the core.

Test Plan:
- Zero-wait memory with program "addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt" -> R3=12, halted=1, illegal=0, pc=0x10, cycle_count=4+4+4+2=14.
- "sw $3,8($0)" then "lw $4,8($0)" with mem_ready delayed 3 cycles on every access -> memory word 2 = R3; R4 = R3; each instruction takes 3 extra cycles per access.
- beq taken (R1==R1, imm=2) at pc=0 -> next fetch address byte 0x0C. Then bne not taken (equal operands) -> pc = branch pc + 4.
- j 0x40 -> pc=0x100. Opcode 0x3E -> halted=1, illegal=1; further run pulses change nothing.
- Toggle run=0 for 5 cycles mid-MEM_READ with mem_ready pulsing -> state, pc and cycle_count unchanged; the load completes after run returns and ready is reasserted.
- rst asserted during FETCH wait -> next cycle pc=0, state=FETCH, cycle_count=0, registers 0. "addi $0,$0,9" -> dbg_index=0 reads 0.
